shiftadd_mult8: RTL and testbench
=================================

# shiftadd_mult8

Sequential unsigned shift-add multiply-accumulate: computes `product = multiplicand * multiplier + addend`, one multiplier bit per clock. It is the recombination end of the 8-bit division datapath: feeding a quotient, divisor and remainder back in reproduces the original dividend. It is used in the assignment bench for divider self-checking and as a standalone arithmetic block.

## Interface
- `W`, default 8: operand width. The product is 2W bits wide.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request. Sampled only when `busy`=0.
- `multiplicand`, input, W: operand A. Captured on the accepted-start edge.
- `multiplier`, input, W: operand B. Captured on the accepted-start edge.
- `addend`, input, W: zero-extended offset C. Captured on the accepted-start edge.
- `product`, output, 2W: result A*B+C. Held stable while `done`=1.
- `busy`, output, 1: high while a computation is in progress.
- `done`, output, 1: high from completion until the next accepted start or reset.

## Operation
- **States**
  - IDLE: `busy`=0. Covers both the post-reset state and the result-hold condition.
  - RUN: `busy`=1.
- **Accept**
  - Condition: IDLE and `start`=1.
  - On that edge: A→a_reg; B→b_reg; acc←{W'b0, C}; step counter←0; `done`←0; `busy`←1; go to RUN.
- **RUN step** (one per edge):
  - acc ← acc + (b_reg[0] ? a_reg<<step : 0).
  - b_reg ← b_reg>>1.
  - step ← step+1.
  - Multiplier bits are processed LSB first.
- **Completion**
  - The edge that performs step W-1 also sets `done`←1 and `busy`←0, and returns to IDLE.
  - `product` mirrors acc.
- **Width rule**
  - Max result is (2^W−1)^2 + (2^W−1) = 2^2W − 2^W, so it fits in 2W bits.
  - No overflow and no carry-out exist. The accumulator is exactly 2W bits.
- **Operand sampling**
  - `start` while `busy`=1 is ignored. It is not queued.
  - Input changes during RUN have no effect.
- **Fixed latency**
  - There is no early termination on zero operands.
  - A=0 or B=0 still takes W steps.
- **Reset**
  - `rst`=1 at any edge (IDLE or mid-RUN) sets: `product`=0, `busy`=0, `done`=0, counter=0, state IDLE.
  - `rst` has priority over `start` on the same edge.
  - The partial result is discarded.
- **Back-to-back operation**
  - `start`=1 in the same cycle `done` is high is accepted.
  - `done` drops on that edge.
  - `product` begins accumulating the new C on that edge.

## Timing
- **Reset values:** `product`=0, `busy`=0, `done`=0.
- **Latency**
  - Accept edge = edge 0.
  - Steps occur on edges 1..W.
  - `done`=1 and final `product` are visible after edge W (W=8: 8 cycles after the accept edge).
- **Throughput:** one operation per W+1 cycles with `start` held high continuously.
- **`busy`**
  - Rises after edge 0 and falls after edge W.
  - `busy` and `done` are never both 1.
- **`product` during RUN**
  - Shows the partial accumulation.
  - It is valid only while `done`=1.
- **`done`:** a level, not a pulse. It stays high indefinitely until the next accepted start or reset.

## Test plan
- **Basic:** A=13, B=11, C=5, `start` for 1 cycle → `busy` high 8 cycles, then `done`=1 with `product`=148 (0x0094), held for ≥10 idle cycles.
- **Extremes:**
  - A=255, B=255, C=255 → `product`=65280 (0xFF00). No wrap.
  - A=0, B=200, C=7 → `product`=7 after exactly 8 step cycles.
- **Divider inverse:** A=15 (quotient), B=13 (divisor), C=5 (remainder) → `product`=200 (dividend). Sweep all 8-bit dividend/divisor≠0 pairs through the divider and this block; every pair must return the dividend.
- **Ignored start:** pulse `start` with A=1, B=1, C=0 at step 3 of the job A=13, B=11, C=5 → result still 148, completion at the original cycle, no second job.
- **Reset mid-run:** assert `rst` for 1 cycle at step 4 → next cycle `product`=0, `busy`=0, `done`=0. A subsequent start of A=3, B=4, C=1 → 13.
- **Back-to-back:** hold `start`=1 with A=2, B=3, C=0, then A=10, B=10, C=9 presented on the cycle the first `done` is high → 6 after 8 cycles, `done` low for exactly 8 cycles, then 109.

Source files
------------

// File: rtl/shiftadd_mult8.sv
// rtl/shiftadd_mult8.sv - sequential unsigned shift-add multiply-accumulate (A*B+C)
module shiftadd_mult8 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   addend,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  step;
  logic [2*W-1:0] a_wide;
  logic [2*W-1:0] partial;
  logic           last_step;

  assign a_wide    = {{W{1'b0}}, a_reg};
  assign partial   = b_reg[0] ? (a_wide << step) : '0;
  assign last_step = (step == CW'(W - 1));
  assign product   = acc;

  // IDLE doubles as the result-hold state, so a new start is accepted while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= multiplicand;
            b_reg <= multiplier;
            acc   <= {{W{1'b0}}, addend};
            step  <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc + partial;
          b_reg <= b_reg >> 1;
          step  <= step + 1'b1;
          if (last_step) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mult8.sv
// tb/tb_shiftadd_mult8.sv - directed self-checking bench for shiftadd_mult8
module tb_shiftadd_mult8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [7:0]  addend;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  shiftadd_mult8 #(.W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [15:0] exp, input string tag);
    int n;
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 32'd8);
    chk(tag, {16'b0, product}, {16'b0, exp});
  endtask

  initial begin
    int n;
    int low;
    int d;
    int v;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;
    addend       = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_product", {16'b0, product}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);

    // basic job: partial product starts at C, then busy for 8 cycles
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    addend       = 8'd5;
    start        = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_acc_init", {16'b0, product}, 32'd5);
    n = 0;
    while (!done && n < 20) begin
      chk("basic_busy_run", {31'b0, busy}, 32'd1);
      tick();
      n++;
    end
    chk("basic_lat", n, 32'd8);
    chk("basic_product", {16'b0, product}, 32'd148);
    chk("basic_busy_low", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("basic_hold_product", {16'b0, product}, 32'd148);
      chk("basic_hold_done", {31'b0, done}, 32'd1);
    end

    run_job(8'd255, 8'd255, 8'd255, 16'hFF00, "max");
    run_job(8'd0, 8'd200, 8'd7, 16'd7, "zero_a");
    run_job(8'd200, 8'd0, 8'd0, 16'd0, "zero_b");
    run_job(8'd15, 8'd13, 8'd5, 16'd200, "div_inverse");

    // divider recombination: q*divisor + r must give back the dividend
    for (int i = 0; i < 40; i++) begin
      d = (i * 37 + 11) % 256;
      v = (i * 53) % 255 + 1;
      run_job(8'(d / v), 8'(v), 8'(d % v), 16'(d), "div_sweep");
    end

    // start pulse mid-run must be ignored
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    addend       = 8'd5;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    multiplicand = 8'd1;
    multiplier   = 8'd1;
    addend       = 8'd0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    n = 4;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("ignored_lat", n, 32'd8);
    chk("ignored_product", {16'b0, product}, 32'd148);
    tick();
    tick();
    chk("ignored_no_second_busy", {31'b0, busy}, 32'd0);
    chk("ignored_no_second_product", {16'b0, product}, 32'd148);

    // reset mid-run discards the partial result
    multiplicand = 8'd13;
    multiplier   = 8'd11;
    addend       = 8'd5;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_product", {16'b0, product}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    tick();
    chk("midrst_stays_idle", {31'b0, busy}, 32'd0);
    run_job(8'd3, 8'd4, 8'd1, 16'd13, "after_rst");

    // reset wins over start on the same edge
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    addend       = 8'd9;
    start        = 1'b1;
    rst          = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_prio_busy", {31'b0, busy}, 32'd0);
    chk("rst_prio_product", {16'b0, product}, 32'd0);

    // back-to-back with start held high
    multiplicand = 8'd2;
    multiplier   = 8'd3;
    addend       = 8'd0;
    start        = 1'b1;
    tick();
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_first_lat", n, 32'd8);
    chk("b2b_first_product", {16'b0, product}, 32'd6);
    multiplicand = 8'd10;
    multiplier   = 8'd10;
    addend       = 8'd9;
    low = 0;
    n   = 0;
    do begin
      tick();
      n++;
      if (!done) low++;
      chk("b2b_excl", {31'b0, busy & done}, 32'd0);
    end while (!done && n < 20);
    start = 1'b0;
    chk("b2b_done_low", low, 32'd8);
    chk("b2b_second_product", {16'b0, product}, 32'd109);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
